// File: rtl/bit4_shift_register_piso_pkg.sv
// Shared types and constants for the PISO serial transmitter.
package piso_pkg;
  typedef enum logic {IDLE, SHIFT} piso_state_t;
  localparam logic PISO_IDLE_BIT = 1'b0;
endpackage

// File: rtl/bit4_shift_register_piso_if.sv
// Load handshake and serial-link signals of the PISO transmitter.
interface bit4_shift_register_piso_if #(parameter int WIDTH = 4) ();
  logic             load_valid;
  logic [WIDTH-1:0] load_data;
  logic             load_ready;
  logic             data_out;
  logic             clk2;
  logic             busy;
  logic             done;

  modport master (output load_valid, load_data,
                  input  load_ready, data_out, clk2, busy, done);
  modport slave  (input  load_valid, load_data,
                  output load_ready, data_out, clk2, busy, done);
endinterface

// File: rtl/bit4_shift_register_piso_clk_div_tick.sv
// Free-running clock divider; tick marks the clk2 falling edge so the receive
// side can reuse the same phase relationship.
module clk_div_tick #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic clr,
  output logic tick,
  output logic clk2
);
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF = CW'(DIV / 2 - 1);

  logic [CW-1:0] div_cnt_q, div_cnt_d;
  logic          clk2_q, clk2_d;

  assign tick = (div_cnt_q == LAST);
  assign clk2 = clk2_q;

  always_comb begin
    div_cnt_d = tick ? '0 : div_cnt_q + CW'(1);
    clk2_d    = (tick || (div_cnt_q == HALF)) ? ~clk2_q : clk2_q;
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      div_cnt_q <= '0;
      clk2_q    <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      clk2_q    <= clk2_d;
    end
  end
endmodule

// File: rtl/bit4_shift_register_piso.sv
// Parallel-in serial-out transmitter: accepts a word over valid/ready and
// sends it one bit per clk2 period, changing data on clk2 falling edges.
module bit4_shift_register_piso
  import piso_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int DIV       = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input logic                         clk,
  input logic                         clr,
  bit4_shift_register_piso_if.slave   bus
);
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH);

  piso_state_t      state_q;
  logic [WIDTH-1:0] shreg_q;
  logic [CNT_W-1:0] bit_cnt_q;
  logic             data_out_q;
  logic             done_q;
  logic             tick;
  logic             clk2;
  logic             next_bit;

  clk_div_tick #(.DIV(DIV)) u_div (
    .clk  (clk),
    .clr  (clr),
    .tick (tick),
    .clk2 (clk2)
  );

  assign next_bit       = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];
  assign bus.clk2       = clk2;
  assign bus.load_ready = (state_q == IDLE);
  assign bus.busy       = (state_q == SHIFT);
  assign bus.data_out   = data_out_q;
  assign bus.done       = done_q;

  // A load in IDLE ignores a coincident tick; the first bit waits for the next one.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q    <= IDLE;
      shreg_q    <= '0;
      bit_cnt_q  <= '0;
      data_out_q <= PISO_IDLE_BIT;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.load_valid) begin
            shreg_q   <= bus.load_data;
            bit_cnt_q <= '0;
            state_q   <= SHIFT;
          end
        end
        SHIFT: begin
          if (tick) begin
            if (bit_cnt_q < LAST_BIT) begin
              data_out_q <= next_bit;
              shreg_q    <= MSB_FIRST ? (shreg_q << 1) : (shreg_q >> 1);
              bit_cnt_q  <= bit_cnt_q + CNT_W'(1);
            end else begin
              data_out_q <= PISO_IDLE_BIT;
              done_q     <= 1'b1;
              state_q    <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bit4_shift_register_piso.sv
// Directed bench for the PISO transmitter with an expected-bit scoreboard.
module tb_bit4_shift_register_piso;
  localparam int DIV = 4;
  localparam int W   = 4;

  logic clk = 1'b0;
  logic clr = 1'b0;

  bit4_shift_register_piso_if #(.WIDTH(W)) ifm ();
  bit4_shift_register_piso_if #(.WIDTH(W)) ifl ();

  bit4_shift_register_piso #(.WIDTH(W), .DIV(DIV), .MSB_FIRST(1'b1)) dut (
    .clk (clk),
    .clr (clr),
    .bus (ifm)
  );

  bit4_shift_register_piso #(.WIDTH(W), .DIV(DIV), .MSB_FIRST(1'b0)) dut_lsb (
    .clk (clk),
    .clr (clr),
    .bus (ifl)
  );

  always #5 clk = ~clk;

  // Cycles since reset release; cyc % DIV is the divider phase of the current cycle.
  int cyc;
  always @(posedge clk or negedge clr) begin
    if (!clr) cyc <= 0;
    else      cyc <= cyc + 1;
  end

  int   checks = 0;
  int   errors = 0;
  logic exp_q[$];

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chkn(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic timeout(input string tag);
    checks++;
    errors++;
    $display("FAIL %s wait bound expired", tag);
  endtask

  function automatic logic f_dout(input bit lsb);
    return lsb ? ifl.data_out : ifm.data_out;
  endfunction
  function automatic logic f_ready(input bit lsb);
    return lsb ? ifl.load_ready : ifm.load_ready;
  endfunction
  function automatic logic f_busy(input bit lsb);
    return lsb ? ifl.busy : ifm.busy;
  endfunction
  function automatic logic f_done(input bit lsb);
    return lsb ? ifl.done : ifm.done;
  endfunction

  task automatic drive(input bit lsb, input logic v, input logic [W-1:0] d);
    if (lsb) begin
      ifl.load_valid = v;
      ifl.load_data  = d;
    end else begin
      ifm.load_valid = v;
      ifm.load_data  = d;
    end
  endtask

  task automatic align(input int phase);
    int n = 0;
    while ((cyc % DIV) != phase && n < 4 * DIV) begin
      @(negedge clk);
      n++;
    end
    if ((cyc % DIV) != phase) timeout("align");
  endtask

  task automatic check_reset_outputs(input string tag);
    for (int s = 0; s < 2; s++) begin
      chk1({tag, "_dout"},  f_dout(s[0]),  1'b0);
      chk1({tag, "_ready"}, f_ready(s[0]), 1'b1);
      chk1({tag, "_busy"},  f_busy(s[0]),  1'b0);
      chk1({tag, "_done"},  f_done(s[0]),  1'b0);
    end
    chk1({tag, "_clk2"}, ifm.clk2, 1'b0);
  endtask

  // Called at a negedge. chained: valid is already held from the previous word.
  task automatic send(input bit lsb, input logic [W-1:0] word, input bit on_tick,
                      input bit chained, input bit hold_next, input logic [W-1:0] next_word);
    int   lat;
    logic e;
    if (!chained) begin
      align(on_tick ? DIV - 1 : 0);
      drive(lsb, 1'b1, word);
    end
    chk1("ready_at_offer", f_ready(lsb), 1'b1);
    for (int i = 0; i < W; i++) exp_q.push_back(lsb ? word[i] : word[W-1-i]);
    @(posedge clk);
    #1;
    if (hold_next) drive(lsb, 1'b1, next_word);
    else           drive(lsb, 1'b0, '0);
    @(negedge clk);
    chk1("busy_after_accept", f_busy(lsb), 1'b1);
    chk1("done_low_after_accept", f_done(lsb), 1'b0);
    lat = 0;
    while ((cyc % DIV) != DIV - 1 && lat < 2 * DIV) begin
      chk1("dout_before_first_bit", f_dout(lsb), 1'b0);
      @(negedge clk);
      lat++;
    end
    chk1("dout_in_tick_before_first_bit", f_dout(lsb), 1'b0);
    @(negedge clk);
    lat++;
    chkn("first_bit_latency", lat, on_tick ? DIV : DIV - 1);
    for (int b = 0; b < W; b++) begin
      if (exp_q.size() == 0) begin
        timeout("scoreboard_empty");
        e = 1'b0;
      end else begin
        e = exp_q.pop_front();
      end
      for (int k = 0; k < DIV; k++) begin
        chk1($sformatf("bit%0d_cyc%0d", b, k), f_dout(lsb), e);
        chk1("ready_low_while_busy", f_ready(lsb), 1'b0);
        chk1("done_low_while_busy", f_done(lsb), 1'b0);
        @(negedge clk);
      end
    end
    chk1("done_pulse", f_done(lsb), 1'b1);
    chk1("dout_idle_after", f_dout(lsb), 1'b0);
    chk1("ready_in_done_cycle", f_ready(lsb), 1'b1);
    chk1("busy_low_in_done_cycle", f_busy(lsb), 1'b0);
    if (!hold_next) begin
      @(negedge clk);
      chk1("done_one_cycle", f_done(lsb), 1'b0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    drive(1'b0, 1'b0, '0);
    drive(1'b1, 1'b0, '0);
    clr = 1'b0;
    repeat ($urandom_range(2, 5)) @(negedge clk);
    check_reset_outputs("reset_initial");
    clr = 1'b1;
    for (int k = 0; k < DIV / 2; k++) begin
      @(negedge clk);
      chk1($sformatf("clk2_after_release_%0d", k), ifm.clk2, (k == DIV / 2 - 1) ? 1'b1 : 1'b0);
    end

    send(1'b0, 4'b1011, 1'b0, 1'b0, 1'b0, '0);
    send(1'b1, 4'b0001, 1'b0, 1'b0, 1'b0, '0);

    // Second word held during the first transfer must be taken in the done cycle.
    send(1'b0, 4'b1011, 1'b0, 1'b0, 1'b1, 4'b1111);
    send(1'b0, 4'b1111, 1'b0, 1'b1, 1'b0, '0);
    for (int k = 0; k < 2 * DIV; k++) begin
      chk1("no_duplicate_accept", f_busy(1'b0), 1'b0);
      @(negedge clk);
    end

    send(1'b0, 4'b0110, 1'b1, 1'b0, 1'b0, '0);
    send(1'b1, 4'b1100, 1'b1, 1'b0, 1'b0, '0);

    // Reset during the second bit of 1101.
    align(0);
    drive(1'b0, 1'b1, 4'b1101);
    @(posedge clk);
    #1;
    drive(1'b0, 1'b0, '0);
    repeat (8) @(posedge clk);
    @(negedge clk);
    chk1("second_bit_before_reset", f_dout(1'b0), 1'b1);
    chk1("busy_before_reset", f_busy(1'b0), 1'b1);
    #2;
    clr = 1'b0;
    #1;
    check_reset_outputs("reset_mid_transfer");
    repeat ($urandom_range(1, 5)) @(negedge clk);
    check_reset_outputs("reset_held");
    clr = 1'b1;
    for (int k = 0; k < 2 * DIV; k++) begin
      @(negedge clk);
      chk1("no_done_after_abort", f_done(1'b0), 1'b0);
      chk1("idle_after_abort", f_busy(1'b0), 1'b0);
      if (k < DIV / 2)
        chk1($sformatf("clk2_after_abort_%0d", k), ifm.clk2, (k == DIV / 2 - 1) ? 1'b1 : 1'b0);
    end
    send(1'b0, 4'b1001, 1'b0, 1'b0, 1'b0, '0);

    chkn("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/bit4_shift_register_piso.md
# bit4_shift_register_piso

Parallel-in, serial-out 4-bit shift register that transmits a loaded nibble one bit per slow-clock period. It is the transmit end of the serial link that the slow 4-bit serial-in register receives: it generates the same divided clock `clk2`, changes `data_out` on the falling edge of `clk2`, and the receiver samples on the rising edge. A simple valid/ready load handshake feeds it from upstream logic.

## Interface
- `WIDTH`, default 4: shift length in bits; must be ≥ 1.
- `DIV`, default 4: `clk` cycles per `clk2` period; must be even and ≥ 2.
- `MSB_FIRST`, default 1: 1 sends bit `WIDTH-1` first; 0 sends bit 0 first.
- `clk`, input, 1: system clock; all state updates on the rising edge.
- `clr`, input, 1: asynchronous, active-low reset.
- `load_valid`, input, 1: upstream offers `load_data`.
- `load_data`, input, `WIDTH`: parallel word to transmit.
- `load_ready`, output, 1: block accepts a word this cycle; high only in IDLE.
- `data_out`, output, 1: serial data; idle level 0.
- `clk2`, output, 1: registered divided clock, 50% duty, period `DIV` cycles.
- `busy`, output, 1: high in SHIFT.
- `done`, output, 1: one-cycle pulse when the last bit period ends.

## Operation
- **Divider.**
  - `div_cnt` runs 0..`DIV-1` freely from reset and wraps.
  - `tick` is `div_cnt == DIV-1`.
  - `clk2` toggles on the edge where `div_cnt == DIV/2-1` and on every tick edge.
  - Result: each tick edge is a `clk2` falling edge.
- **IDLE.**
  - `load_ready` = 1, `busy` = 0, `data_out` = 0.
  - On `load_valid && load_ready`: capture `load_data` into `shreg`, clear `bit_cnt`, go to SHIFT.
  - A load in a tick cycle does not consume that tick.
- **SHIFT.**
  - On each tick while `bit_cnt < WIDTH`: `data_out` takes the next bit (MSB or LSB per `MSB_FIRST`), `shreg` shifts, `bit_cnt` increments.
  - On the tick where `bit_cnt == WIDTH`: `data_out` returns to 0, `done` pulses in the following cycle, state goes to IDLE.
  - Each bit is held for exactly `DIV` cycles, i.e. one full `clk2` period.
- **Load while busy.** `load_valid` is ignored. Upstream must hold `valid` and `data` until it sees `ready`. A word is never dropped or double-accepted.
- **Reset.**
  - Reset values: `div_cnt` = 0, `clk2` = 0, `data_out` = 0, `busy` = 0, `done` = 0, `load_ready` = 1, `shreg` = 0, `bit_cnt` = 0, state IDLE.
  - Reset mid-transfer aborts the transfer immediately, with no `done`.
- **Widths.** `bit_cnt` is `$clog2(WIDTH+1)` bits; `div_cnt` is `$clog2(DIV)` bits.

## Timing
- Load handshake: zero-latency `ready`; acceptance is visible as `busy` = 1 in the next cycle.
- First bit appears 1..`DIV` cycles after acceptance, at the first tick strictly after the accept cycle.
- A transfer occupies `WIDTH+1` ticks after that first tick boundary.
- `done` is asserted for exactly one cycle, the cycle after the final tick. `load_ready` rises in that same cycle.
- Minimum spacing between accepted words: (`WIDTH+1`)·`DIV` cycles, plus alignment to the next tick.
- `clk2` keeps running in IDLE, so the receiver's clock is never gated.

## Structure
- Package `piso_pkg` holds:
  - `typedef enum logic {IDLE, SHIFT} piso_state_t`;
  - the idle-level constant `PISO_IDLE_BIT = 1'b0`.
- Sub-module `clk_div_tick` contains the divider, producing `tick` and `clk2`. It has parameter `DIV`, ports `clk` and `clr`, and is reusable by the receive side.
- Top module holds the FSM, `shreg`, `bit_cnt`, and the output registers.

## Test plan
- **Reset.** Hold `clr` = 0 at random points → `data_out` = 0, `clk2` = 0, `load_ready` = 1, `busy` = 0, `done` = 0. After release, `clk2` first rises after `DIV/2` cycles.
- **MSB-first transfer.** `DIV` = 4, `MSB_FIRST` = 1; load `4'b1011` when `div_cnt` = 0 → `data_out` shows 1, 0, 1, 1, each held 4 cycles starting 3 cycles after accept. Then `data_out` = 0, `done` pulses one cycle, `load_ready` returns to 1.
- **LSB-first transfer.** `MSB_FIRST` = 0; load `4'b0001` → bit sequence 1, 0, 0, 0.
- **Load while busy.** Hold `load_valid` = 1 with `4'b1111` during a `4'b1011` transfer → second word accepted only in the `done` cycle. Both words are transmitted in order and none is duplicated.
- **Load on a tick.** Load exactly in a tick cycle → first bit appears `DIV` cycles later, not in the same cycle.
- **Reset mid-transfer.** Assert `clr` after the 2nd bit → outputs go to reset values immediately. No `done` pulse occurs. A new load after release transmits cleanly.
